// File: rtl/lsu_bus_ctrl_if.sv
// Core-side request/response and data-bus signals of the load/store bus
// controller. 'master' is the controller's view, 'slave' is the view of the
// environment (core pipeline plus data bus).
interface lsu_bus_ctrl_if;
  // core request
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [31:0] req_addr;
  logic [2:0]  req_size;
  logic [3:0]  req_strobe;
  logic [31:0] req_wdata;
  logic        req_signed;
  logic        flush;
  // data bus
  logic        dbus_valid;
  logic [31:0] dbus_addr;
  logic [2:0]  dbus_size;
  logic [3:0]  dbus_strobe;
  logic [31:0] dbus_data;
  logic        dbus_addr_ok;
  logic        dbus_data_ok;
  logic [31:0] dbus_rdata;
  // core response / status
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        busy;
  logic        bus_timeout;

  modport master (
    input  req_valid, req_store, req_addr, req_size, req_strobe, req_wdata,
           req_signed, flush, dbus_addr_ok, dbus_data_ok, dbus_rdata,
    output req_ready, dbus_valid, dbus_addr, dbus_size, dbus_strobe,
           dbus_data, resp_valid, resp_data, busy, bus_timeout
  );

  modport slave (
    output req_valid, req_store, req_addr, req_size, req_strobe, req_wdata,
           req_signed, flush, dbus_addr_ok, dbus_data_ok, dbus_rdata,
    input  req_ready, dbus_valid, dbus_addr, dbus_size, dbus_strobe,
           dbus_data, resp_valid, resp_data, busy, bus_timeout
  );
endinterface

// File: rtl/lsu_bus_ctrl.sv
// Load/store bus controller: one outstanding access, two-phase bus handshake
// (addr_ok then data_ok), load alignment/extension, flush kill and a sticky
// watchdog flag for stalled transfers.
module lsu_bus_ctrl #(
  parameter int WATCHDOG = 256
) (
  input  logic          clk,
  input  logic          resetn,
  lsu_bus_ctrl_if.master b
);
  localparam logic [2:0] MSIZE1 = 3'b001;
  localparam logic [2:0] MSIZE2 = 3'b010;
  localparam logic [2:0] MSIZE4 = 3'b100;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  // latched request; strobe is already forced to 0 for loads
  typedef struct packed {
    logic        store;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [3:0]  strobe;
    logic [31:0] wdata;
    logic        sgn;
  } req_t;

  state_t      state, state_nxt;
  req_t        rq;
  logic        accept, capture, wd_wait;
  logic        kill;
  logic [31:0] wd_cnt;
  logic        timeout;
  logic [31:0] resp_q;

  // shift the addressed bytes down to bit 0, then extend to 32 bits
  function automatic logic [31:0] align_load(input logic [31:0] rdata,
                                             input logic [1:0]  sh,
                                             input logic [2:0]  size,
                                             input logic        sgn);
    logic [31:0] s;
    s = rdata >> {sh, 3'b000};
    case (size)
      MSIZE1:  return {{24{sgn & s[7]}}, s[7:0]};
      MSIZE2:  return {{16{sgn & s[15]}}, s[15:0]};
      MSIZE4:  return rdata;
      default: return rdata;
    endcase
  endfunction

  // next-state and handshake decode; flush blocks acceptance in IDLE
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (b.req_valid && !b.flush) begin
          accept    = 1'b1;
          state_nxt = ADDR;
        end
      end
      ADDR: begin
        if (b.dbus_addr_ok) begin
          if (b.dbus_data_ok) begin
            capture   = 1'b1;
            state_nxt = RESP;
          end else begin
            state_nxt = DATA;
          end
        end
      end
      DATA: begin
        if (b.dbus_data_ok) begin
          capture   = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // request latch; fields stay stable for the whole bus transaction
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rq <= '0;
    end else if (accept) begin
      rq.store  <= b.req_store;
      rq.addr   <= b.req_addr;
      rq.size   <= b.req_size;
      rq.strobe <= b.req_store ? b.req_strobe : 4'h0;
      rq.wdata  <= b.req_wdata;
      rq.sgn    <= b.req_signed;
    end
  end

  // response data is computed at data_ok and held until the next capture
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)      resp_q <= '0;
    else if (capture) resp_q <= rq.store ? 32'h0
                                         : align_load(b.dbus_rdata, rq.addr[1:0], rq.size, rq.sgn);
  end

  // kill bit: set by flush while a transaction is open, dropped in RESP/IDLE;
  // a flush seen during RESP itself is handled combinationally below
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) kill <= 1'b0;
    else         kill <= ((state == ADDR) || (state == DATA)) && (kill || b.flush);
  end

  assign wd_wait = (state == ADDR) || (state == DATA);

  // watchdog counter, saturating so a very long stall cannot wrap it
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                          wd_cnt <= '0;
    else if (accept)                      wd_cnt <= '0;
    else if (wd_wait && (wd_cnt != '1))   wd_cnt <= wd_cnt + 32'd1;
  end

  // sticky timeout, raised on the edge the counter reaches the limit
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      timeout <= 1'b0;
    else if ((WATCHDOG != 0) && wd_wait && ((wd_cnt + 32'd1) == 32'(WATCHDOG)))
      timeout <= 1'b1;
  end

  assign b.req_ready   = (state == IDLE);
  assign b.dbus_valid  = (state == ADDR);
  assign b.dbus_addr   = rq.addr;
  assign b.dbus_size   = rq.size;
  assign b.dbus_strobe = rq.strobe;
  assign b.dbus_data   = rq.wdata;
  assign b.resp_valid  = (state == RESP) && !kill && !b.flush;
  assign b.resp_data   = resp_q;
  assign b.busy        = (state != IDLE);
  assign b.bus_timeout = timeout;

endmodule

// File: doc/lsu_bus_ctrl.md
Name: lsu_bus_ctrl

Overview:
- Sequences one load or store at a time onto the data bus, after the address-check stage has produced a word-aligned-lane request (address, size, byte strobe, lane-replicated store data).
- Implements the two-phase bus handshake: hold the request until the bus accepts the address (addr_ok), then wait for data completion (data_ok).
- Aligns and sign/zero-extends load data, then returns a single-cycle response to the core.
- Handles flush without violating the bus protocol, and flags a stall that exceeds a watchdog limit.

Parameters:
- WATCHDOG, 256, cycles allowed from request acceptance to data_ok before bus_timeout asserts; 0 disables the watchdog.

Ports:
- clk  in  1  core clock
- resetn  in  1  asynchronous active-low reset
- req_valid  in  1  core has a memory request
- req_ready  out  1  controller can accept a request this cycle
- req_store  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_size  in  3  MSIZE1/MSIZE2/MSIZE4 encoding
- req_strobe  in  4  byte-lane strobe; meaningful for stores only
- req_wdata  in  32  lane-replicated store data
- req_signed  in  1  load sign-extends (LB/LH) when 1, zero-extends (LBU/LHU) when 0
- flush  in  1  discard the in-flight response
- dbus_valid  out  1  bus request valid
- dbus_addr  out  32  bus address
- dbus_size  out  3  bus size
- dbus_strobe  out  4  bus strobe; 0 for loads
- dbus_data  out  32  bus write data
- dbus_addr_ok  in  1  bus accepted address
- dbus_data_ok  in  1  bus completed transfer
- dbus_rdata  in  32  bus read data, valid with data_ok
- resp_valid  out  1  one-cycle completion pulse
- resp_data  out  32  aligned and extended load result; 0 for stores
- busy  out  1  controller not in IDLE
- bus_timeout  out  1  sticky watchdog error flag

Behaviour:
- Reset (async, resetn low): state IDLE; dbus_valid 0; all dbus_* outputs 0; resp_valid 0; resp_data 0; bus_timeout 0; internal registers cleared. Reset asserted mid-transaction abandons it immediately.
- States: IDLE, ADDR, DATA, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid, latch all req_* fields and go to ADDR.
  - dbus_valid asserts the next cycle (registered request).
- ADDR:
  - dbus_valid = 1 with the latched fields held stable.
  - On addr_ok & data_ok in the same cycle: capture rdata and go to RESP.
  - On addr_ok alone: go to DATA.
  - Otherwise stay in ADDR.
  - Never deassert dbus_valid before addr_ok, even under flush.
- DATA:
  - dbus_valid = 0.
  - On data_ok: capture rdata and go to RESP.
- RESP:
  - resp_valid = 1 for exactly one cycle, unless the request was flushed.
  - Return to IDLE; req_ready = 0 in this cycle, so a new request is accepted the cycle after RESP.
- Minimum latency (addr_ok and data_ok in the first ADDR cycle): request accepted in cycle 0, resp_valid in cycle 2.
- Flush:
  - Sets a sticky kill bit when asserted in ADDR, DATA, or RESP; the bit also sets in the cycle flush is sampled.
  - The bus handshake still completes normally.
  - resp_valid is suppressed; the kill bit clears on return to IDLE.
  - Flush in IDLE has no effect; a request with req_valid and flush both high in IDLE is not accepted.
- Load alignment:
  - sh = req_addr[1:0]; shifted = rdata >> (8*sh).
  - MSIZE1: result is shifted[7:0], sign- or zero-extended.
  - MSIZE2: result is shifted[15:0], sign- or zero-extended.
  - MSIZE4: result is rdata unchanged.
  - resp_data for a store is 0.
  - resp_data holds its value until the next RESP.
- Watchdog:
  - Counter clears on request acceptance and increments every cycle in ADDR or DATA.
  - When the counter reaches WATCHDOG (nonzero), bus_timeout sets and stays set until reset.
  - The FSM keeps waiting; the watchdog does not force completion.
- busy = (state != IDLE).
- Spurious data_ok in IDLE or ADDR without a prior addr_ok is ignored, except for the same-cycle addr_ok & data_ok case in ADDR.

Test Plan:
- Load word: addr 0x1000, MSIZE4; addr_ok and data_ok both given in the first ADDR cycle, rdata 0xDEADBEEF -> resp_valid pulses in cycle 2 with resp_data 0xDEADBEEF; dbus_strobe 0.
- Signed byte load: addr 0x1003, MSIZE1, signed, rdata 0x80FF0000 -> resp_data 0xFFFFFF80. Same request unsigned -> resp_data 0x00000080.
- Store halfword with bus stalls: addr 0x2002, strobe 0xC, data 0x12341234; addr_ok delayed 3 cycles, data_ok 2 cycles later -> dbus_valid high for exactly 4 cycles with stable fields; resp_valid one pulse; resp_data 0.
- Flush during DATA on a load -> no resp_valid; FSM returns to IDLE after data_ok; the next request completes normally.
- Flush during ADDR -> dbus_valid stays high until addr_ok; response suppressed.
- WATCHDOG=8, bus never responds -> bus_timeout asserts 8 cycles after acceptance and stays set. Then assert resetn low mid-transaction -> all outputs 0 immediately and state IDLE.
